// File: rtl/spi_pkg.sv
// Shared SPI definitions: master FSM states, clock mode constants and the
// switch port count used by the crossbar that these masters sit behind.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SS_SETUP,
        ST_SHIFT,
        ST_SS_HOLD,
        ST_DONE
    } spi_state_t;

    // SCK idle level (CPOL)
    localparam logic CPOL_IDLE_LOW  = 1'b0;
    localparam logic CPOL_IDLE_HIGH = 1'b1;

    // Sampling edge (CPHA)
    localparam logic CPHA_SAMPLE_LEAD  = 1'b0;
    localparam logic CPHA_SAMPLE_TRAIL = 1'b1;

    // Number of lanes on the SPI crossbar switch
    localparam int unsigned SPI_SWITCH_PORTS = 8;

endpackage

// File: rtl/spi_sck_timer.sv
// Down-counter used for both SCK half periods and slave-select guard time.
// Loading N-1 makes tick assert N clock cycles after the load edge.
module spi_sck_timer #(
    parameter int TIMER_WID = 8
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic                 load,
    input  logic [TIMER_WID-1:0] load_val,
    output logic                 tick
);

    logic [TIMER_WID-1:0] count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/spi_master_ss.sv
// Single-lane SPI master with slave-select sequencing and a level
// arm/finished handshake towards the kernel.
module spi_master_ss
    import spi_pkg::*;
#(
    parameter int   WID             = 24,
    parameter int   CYCLE_HALF_WAIT = 1,
    parameter int   TIMER_WID       = 8,
    parameter int   SS_WAIT         = 1,
    parameter logic POLARITY        = CPOL_IDLE_LOW,
    parameter logic PHASE           = CPHA_SAMPLE_LEAD
) (
    input  logic           clk,
    input  logic           rst_L,
    input  logic [WID-1:0] to_slave,
    output logic [WID-1:0] from_slave,
    input  logic           arm,
    output logic           ready_to_arm,
    output logic           finished,
    output logic           mosi,
    input  logic           miso,
    output logic           sck,
    output logic           ss_L
);

    localparam int                   CNT_WID   = $clog2(2 * WID + 1);
    localparam logic [CNT_WID-1:0]   LAST_TOG  = CNT_WID'(2 * WID);
    localparam logic [CNT_WID-1:0]   FINAL_TOG = CNT_WID'(2 * WID - 1);
    localparam logic [TIMER_WID-1:0] HALF_LOAD = TIMER_WID'(CYCLE_HALF_WAIT - 1);
    localparam logic [TIMER_WID-1:0] SS_LOAD   = TIMER_WID'(SS_WAIT - 1);

    spi_state_t           state;
    logic [WID-1:0]       tx_sr;
    logic [WID-1:0]       rx_sr;
    logic [CNT_WID-1:0]   tog_cnt;
    logic                 timer_load;
    logic [TIMER_WID-1:0] timer_val;
    logic                 tick;

    spi_sck_timer #(.TIMER_WID(TIMER_WID)) u_timer (
        .clk      (clk),
        .rst_L    (rst_L),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (tick)
    );

    // Timer reload: SS guard on arm and after the last toggle, half period otherwise
    always_comb begin
        timer_load = 1'b0;
        timer_val  = SS_LOAD;
        case (state)
            ST_IDLE: begin
                timer_load = arm;
            end
            ST_SS_SETUP, ST_SHIFT: begin
                timer_load = tick;
                timer_val  = (tog_cnt == LAST_TOG) ? SS_LOAD : HALF_LOAD;
            end
            default: ;
        endcase
    end

    // Transfer sequencer; every SCK toggle happens on a timer tick, the first
    // one on the SS_SETUP expiry so ss_L-to-first-edge equals the guard time
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state        <= ST_IDLE;
            sck          <= POLARITY;
            ss_L         <= 1'b1;
            mosi         <= 1'b0;
            finished     <= 1'b0;
            ready_to_arm <= 1'b1;
            from_slave   <= '0;
            tx_sr        <= '0;
            rx_sr        <= '0;
            tog_cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        tx_sr        <= to_slave;
                        rx_sr        <= '0;
                        tog_cnt      <= '0;
                        ss_L         <= 1'b0;
                        ready_to_arm <= 1'b0;
                        if (PHASE == CPHA_SAMPLE_LEAD) begin
                            mosi <= to_slave[WID-1];
                        end
                        state <= ST_SS_SETUP;
                    end
                end
                ST_SS_SETUP, ST_SHIFT: begin
                    if (tick) begin
                        if (tog_cnt == LAST_TOG) begin
                            state <= ST_SS_HOLD;
                        end else begin
                            state   <= ST_SHIFT;
                            sck     <= ~sck;
                            tog_cnt <= tog_cnt + 1'b1;
                            if (!tog_cnt[0]) begin
                                // leading edge
                                if (PHASE == CPHA_SAMPLE_LEAD) begin
                                    rx_sr <= {rx_sr[WID-2:0], miso};
                                end else begin
                                    mosi  <= tx_sr[WID-1];
                                    tx_sr <= {tx_sr[WID-2:0], 1'b0};
                                end
                            end else begin
                                // trailing edge
                                if (PHASE == CPHA_SAMPLE_LEAD) begin
                                    if (tog_cnt != FINAL_TOG) begin
                                        mosi  <= tx_sr[WID-2];
                                        tx_sr <= {tx_sr[WID-2:0], 1'b0};
                                    end
                                end else begin
                                    rx_sr <= {rx_sr[WID-2:0], miso};
                                end
                            end
                        end
                    end
                end
                ST_SS_HOLD: begin
                    if (tick) begin
                        ss_L       <= 1'b1;
                        from_slave <= rx_sr;
                        finished   <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!arm) begin
                        finished     <= 1'b0;
                        ready_to_arm <= 1'b1;
                        state        <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ss.sv
// Bench for spi_master_ss: six instances covering the default 24-bit lane,
// all four CPOL/CPHA modes at 8 bits and a slow 16-bit lane, each talking
// to a behavioural SPI slave.
module tb_spi_master_ss;

    localparam int   NI = 6;
    localparam int   W   [NI] = '{24, 8, 8, 8, 8, 16};
    localparam int   CHW [NI] = '{1, 1, 1, 1, 1, 3};
    localparam int   SSW [NI] = '{1, 1, 1, 1, 1, 4};
    localparam logic POL [NI] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic PHA [NI] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    logic          clk = 1'b0;
    logic          rst_L = 1'b0;
    logic [NI-1:0] arm = '0;
    logic [NI-1:0] rdy, fin, mosi, sck, ss_L;
    logic [NI-1:0] miso = '0;
    logic [23:0]   to_s [NI];
    logic [23:0]   fs   [NI];
    logic [23:0]   fs0;
    logic [7:0]    fs1, fs2, fs3, fs4;
    logic [15:0]   fs5;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // slave model state
    logic [23:0]   s_tx [NI];
    logic [23:0]   s_rx [NI];
    int            s_idx [NI], s_edges [NI], first_dly [NI], hp_err [NI];
    int            ss_falls [NI], last_cyc [NI], fall_cyc [NI];
    logic [NI-1:0] sck_prev = '0;
    logic [NI-1:0] ss_prev  = '1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    always_comb begin
        fs[0] = fs0;
        fs[1] = {16'h0, fs1};
        fs[2] = {16'h0, fs2};
        fs[3] = {16'h0, fs3};
        fs[4] = {16'h0, fs4};
        fs[5] = {8'h0, fs5};
    end

    spi_master_ss #(.WID(24), .CYCLE_HALF_WAIT(1), .TIMER_WID(8), .SS_WAIT(1), .POLARITY(1'b0), .PHASE(1'b0)) u_dut0 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[0]), .from_slave(fs0), .arm(arm[0]), .ready_to_arm(rdy[0]),
        .finished(fin[0]), .mosi(mosi[0]), .miso(miso[0]), .sck(sck[0]), .ss_L(ss_L[0]));
    spi_master_ss #(.WID(8), .CYCLE_HALF_WAIT(1), .TIMER_WID(8), .SS_WAIT(1), .POLARITY(1'b0), .PHASE(1'b0)) u_dut1 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[1][7:0]), .from_slave(fs1), .arm(arm[1]), .ready_to_arm(rdy[1]),
        .finished(fin[1]), .mosi(mosi[1]), .miso(miso[1]), .sck(sck[1]), .ss_L(ss_L[1]));
    spi_master_ss #(.WID(8), .CYCLE_HALF_WAIT(1), .TIMER_WID(8), .SS_WAIT(1), .POLARITY(1'b0), .PHASE(1'b1)) u_dut2 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[2][7:0]), .from_slave(fs2), .arm(arm[2]), .ready_to_arm(rdy[2]),
        .finished(fin[2]), .mosi(mosi[2]), .miso(miso[2]), .sck(sck[2]), .ss_L(ss_L[2]));
    spi_master_ss #(.WID(8), .CYCLE_HALF_WAIT(1), .TIMER_WID(8), .SS_WAIT(1), .POLARITY(1'b1), .PHASE(1'b0)) u_dut3 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[3][7:0]), .from_slave(fs3), .arm(arm[3]), .ready_to_arm(rdy[3]),
        .finished(fin[3]), .mosi(mosi[3]), .miso(miso[3]), .sck(sck[3]), .ss_L(ss_L[3]));
    spi_master_ss #(.WID(8), .CYCLE_HALF_WAIT(1), .TIMER_WID(8), .SS_WAIT(1), .POLARITY(1'b1), .PHASE(1'b1)) u_dut4 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[4][7:0]), .from_slave(fs4), .arm(arm[4]), .ready_to_arm(rdy[4]),
        .finished(fin[4]), .mosi(mosi[4]), .miso(miso[4]), .sck(sck[4]), .ss_L(ss_L[4]));
    spi_master_ss #(.WID(16), .CYCLE_HALF_WAIT(3), .TIMER_WID(8), .SS_WAIT(4), .POLARITY(1'b0), .PHASE(1'b0)) u_dut5 (
        .clk(clk), .rst_L(rst_L), .to_slave(to_s[5][15:0]), .from_slave(fs5), .arm(arm[5]), .ready_to_arm(rdy[5]),
        .finished(fin[5]), .mosi(mosi[5]), .miso(miso[5]), .sck(sck[5]), .ss_L(ss_L[5]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] msk(input int w);
        return (24'd1 << w) - 24'd1;
    endfunction

    // Behavioural SPI slaves: shift s_tx out on miso, capture mosi into s_rx,
    // and log SCK edge timing relative to the clk cycle counter
    always @(sck or ss_L or rst_L) begin
        for (int g = 0; g < NI; g++) begin
            if (!rst_L) begin
                ss_prev[g]  = ss_L[g];
                sck_prev[g] = sck[g];
            end else begin
                if (ss_L[g] != ss_prev[g]) begin
                    ss_prev[g] = ss_L[g];
                    if (!ss_L[g]) begin
                        ss_falls[g]++;
                        s_idx[g]    = 0;
                        s_edges[g]  = 0;
                        s_rx[g]     = '0;
                        hp_err[g]   = 0;
                        first_dly[g] = -1;
                        fall_cyc[g] = cyc;
                        chk($sformatf("sck_idle_at_ss_fall[%0d]", g), 32'(sck[g]), 32'(POL[g]));
                        if (PHA[g] == 1'b0) miso[g] = s_tx[g][W[g]-1];
                    end
                end
                if (sck[g] != sck_prev[g]) begin
                    sck_prev[g] = sck[g];
                    if (!ss_L[g]) begin
                        s_edges[g]++;
                        if (s_edges[g] == 1) first_dly[g] = cyc - fall_cyc[g];
                        else if (cyc - last_cyc[g] != CHW[g]) hp_err[g]++;
                        last_cyc[g] = cyc;
                        if (PHA[g] == 1'b0) begin
                            if (sck[g] != POL[g]) begin
                                s_rx[g] = {s_rx[g][22:0], mosi[g]};
                            end else begin
                                s_idx[g]++;
                                if (s_idx[g] < W[g]) miso[g] = s_tx[g][W[g]-1-s_idx[g]];
                            end
                        end else begin
                            if (sck[g] != POL[g]) begin
                                if (s_idx[g] < W[g]) miso[g] = s_tx[g][W[g]-1-s_idx[g]];
                                s_idx[g]++;
                            end else begin
                                s_rx[g] = {s_rx[g][22:0], mosi[g]};
                            end
                        end
                    end
                end
            end
        end
    end

    // Count clk edges (including the one sampling arm) until finished is seen
    task automatic wait_fin(input int idx, output int lat);
        logic done;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 1000) begin
            @(posedge clk);
            lat++;
            #1;
            if (lat == 1) to_s[idx] = ~to_s[idx];
            done = fin[idx];
        end
        chk($sformatf("finished_timeout[%0d]", idx), 32'(done), 32'd1);
    endtask

    task automatic start(input int idx, input logic [23:0] tx, input logic [23:0] rx);
        s_tx[idx] = rx;
        to_s[idx] = tx;
        @(negedge clk);
        arm[idx] = 1'b1;
    endtask

    task automatic xfer(input int idx, input logic [23:0] tx, input logic [23:0] rx, input int exp_lat);
        int lat;
        logic [23:0] m;
        m = msk(W[idx]);
        start(idx, tx, rx);
        wait_fin(idx, lat);
        chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(exp_lat));
        chk($sformatf("from_slave[%0d]", idx), 32'(fs[idx]), 32'(rx & m));
        chk($sformatf("mosi_stream[%0d]", idx), 32'(s_rx[idx] & m), 32'(tx & m));
        chk($sformatf("first_edge_dly[%0d]", idx), 32'(first_dly[idx]), 32'(SSW[idx]));
        chk($sformatf("half_period_err[%0d]", idx), 32'(hp_err[idx]), 32'd0);
        chk($sformatf("sck_edges[%0d]", idx), 32'(s_edges[idx]), 32'(2 * W[idx]));
        chk($sformatf("sck_idle_at_end[%0d]", idx), 32'(sck[idx]), 32'(POL[idx]));
        chk($sformatf("ss_high_at_end[%0d]", idx), 32'(ss_L[idx]), 32'd1);
    endtask

    task automatic release_arm(input int idx);
        @(negedge clk);
        arm[idx] = 1'b0;
        @(posedge clk);
        #1;
        chk($sformatf("ready_after_release[%0d]", idx), 32'(rdy[idx]), 32'd1);
        chk($sformatf("finished_after_release[%0d]", idx), 32'(fin[idx]), 32'd0);
    endtask

    typedef struct {
        int          idx;
        logic [23:0] tx;
        logic [23:0] rx;
        int          lat;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int falls;

        vecs[0] = '{0, 24'hA5C3F0, 24'h123456, 51};
        vecs[1] = '{1, 24'h000081, 24'h00007E, 19};
        vecs[2] = '{2, 24'h000081, 24'h00007E, 19};
        vecs[3] = '{3, 24'h000081, 24'h00007E, 19};
        vecs[4] = '{4, 24'h000081, 24'h00007E, 19};
        vecs[5] = '{5, 24'h00BEEF, 24'h005A3C, 105};
        vecs[6] = '{0, 24'h000001, 24'hFFFFFE, 51};

        for (int i = 0; i < NI; i++) begin
            to_s[i] = '0;
            s_tx[i] = '0;
        end

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("rst_sck[%0d]", i), 32'(sck[i]), 32'(POL[i]));
            chk($sformatf("rst_ss_L[%0d]", i), 32'(ss_L[i]), 32'd1);
            chk($sformatf("rst_mosi[%0d]", i), 32'(mosi[i]), 32'd0);
            chk($sformatf("rst_ready[%0d]", i), 32'(rdy[i]), 32'd1);
            chk($sformatf("rst_finished[%0d]", i), 32'(fin[i]), 32'd0);
            chk($sformatf("rst_from_slave[%0d]", i), 32'(fs[i]), 32'd0);
        end
        @(negedge clk);
        rst_L = 1'b1;

        // reset at bit 12 aborts the transfer
        start(0, 24'hA5C3F0, 24'h123456);
        repeat (26) @(posedge clk);
        @(negedge clk);
        rst_L = 1'b0;
        #1;
        chk("abort_ss_L", 32'(ss_L[0]), 32'd1);
        chk("abort_sck", 32'(sck[0]), 32'd0);
        chk("abort_from_slave", 32'(fs[0]), 32'd0);
        chk("abort_finished", 32'(fin[0]), 32'd0);
        chk("abort_ready", 32'(rdy[0]), 32'd1);
        arm[0] = 1'b0;
        @(negedge clk);
        rst_L = 1'b1;
        xfer(0, 24'h3C5A96, 24'h69C3A5, 51);
        release_arm(0);

        // table-driven transfers
        for (int i = 0; i < 7; i++) begin
            xfer(vecs[i].idx, vecs[i].tx, vecs[i].rx, vecs[i].lat);
            release_arm(vecs[i].idx);
        end

        // arm held high after finished: no re-trigger
        xfer(0, 24'h5A5A5A, 24'hC0FFEE, 51);
        falls = ss_falls[0];
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_finished_%0d", k), 32'(fin[0]), 32'd1);
        end
        chk("hold_no_ss_fall", 32'(ss_falls[0]), 32'(falls));
        chk("hold_ss_L", 32'(ss_L[0]), 32'd1);
        release_arm(0);

        // arm dropped at bit 5: transfer completes, finished for one cycle
        start(0, 24'h0F0F0F, 24'h876543);
        repeat (11) @(posedge clk);
        @(negedge clk);
        arm[0] = 1'b0;
        wait_fin(0, lat);
        chk("drop_latency", 32'(lat), 32'd40);
        chk("drop_from_slave", 32'(fs[0]), 32'h876543);
        chk("drop_mosi_stream", 32'(s_rx[0]), 32'h0F0F0F);
        @(posedge clk);
        #1;
        chk("drop_finished_one_cycle", 32'(fin[0]), 32'd0);
        chk("drop_ready", 32'(rdy[0]), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_stays_idle", 32'(ss_L[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
